uart_rx_pynq: RTL

- Serial-to-parallel UART receiver for the PYNQ command path: 8N1 frames on `rx` become bytes.
- Sits directly upstream of the command decoder. It produces `po_data` and a one-cycle `po_flag`, which the decoder consumes in the same cycle.
- A frame whose stop bit is bad is discarded and reported on `frame_err`.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rx_sync_edge.sv | 31 +++
 rtl/uart_rx_pynq.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame layout
// and the clock-to-baud divider used to size bit timers.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_IDX  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus a delay flop that
// turns the synchronized level into a one-cycle falling-edge pulse.
module rx_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic meta;
  logic dly;

  // Resetting to the idle level keeps a quiet line from looking like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      dout <= RST_VAL;
      dly  <= RST_VAL;
    end else begin
      meta <= din;
      dout <= meta;
      dly  <= dout;
    end
  end

  assign fall = dly & ~dout;

endmodule

// File: rtl/uart_rx_pynq.sv
// 8N1 UART receiver for the PYNQ command path: mid-bit sampling, one-cycle
// po_flag on a good byte, one-cycle frame_err on a low stop bit.
module uart_rx_pynq
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  localparam int N    = baud_div(CLK_FREQ, BAUD);
  localparam int HALF = N / 2;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS);
  localparam logic [3:0]    IDX_STOP = 4'(STOP_IDX);

  rx_state_e     state;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_s;
  logic          rx_fall;
  logic          mid;
  logic          last;

  rx_sync_edge #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rx),
    .dout  (rx_s),
    .fall  (rx_fall)
  );

  assign mid  = (baud_cnt == CNT_HALF);
  assign last = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      po_data   <= '0;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (rx_fall) state <= START;
        end
        START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (mid && rx_s) begin
            state    <= IDLE;
            baud_cnt <= '0;
          end else if (last) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= 4'd1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (mid) shreg <= {rx_s, shreg[7:1]};
          if (last) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              state   <= STOP;
              bit_idx <= IDX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave mid stop bit so a start bit right behind it is still caught.
          if (mid) begin
            if (rx_s) begin
              po_data <= shreg;
              po_flag <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
